// File: rtl/ep2_axis_pkg.sv
// ep2_axis_pkg: arbiter FSM states and supported port-count range.
package ep2_axis_pkg;
    typedef enum logic {IDLE, LOCK} arb_state_t;
    localparam int PORT_COUNT_MIN = 2;
    localparam int PORT_COUNT_MAX = 16;
endpackage

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: round-robin pick of the first request after last_grant.
module rr_priority_encoder
    import ep2_axis_pkg::*;
#(
    parameter int N  = PORT_COUNT_MIN,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!grant_valid && req[(int'(last_grant) + k) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(last_grant) + k) % N);
            end
        end
        grant_onehot = grant_valid ? N'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-atomic round-robin AXI-Stream merge.
// AXIS_FRAME_ARBITER_OUTREG_EN adds a 2-entry skid register on the output.
module axis_frame_arbiter
    import ep2_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IF_STREAM  = 1,
    parameter int KEEP_WIDTH = IF_STREAM != 0 ? DATA_WIDTH / 8 : 1,
    parameter int PORT_COUNT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_in_tdata,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_in_tkeep,
    input  logic [PORT_COUNT-1:0]            s_axis_in_tvalid,
    input  logic [PORT_COUNT-1:0]            s_axis_in_tlast,
    output logic [PORT_COUNT-1:0]            s_axis_in_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_out_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_out_tkeep,
    output logic                             m_axis_out_tvalid,
    output logic                             m_axis_out_tlast,
    input  logic                             m_axis_out_tready
);
    localparam int IW = $clog2(PORT_COUNT);
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d, last_grant_q, last_grant_d;
    logic [PORT_COUNT-1:0] grant_oh_q, grant_oh_d, enc_onehot;
    logic [IW-1:0]         enc_idx;
    logic                  enc_valid, out_ready, hs, g_valid, g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic [KEEP_WIDTH-1:0] g_keep;

    rr_priority_encoder #(.N(PORT_COUNT), .IW(IW)) u_enc (
        .req          (s_axis_in_tvalid),
        .last_grant   (last_grant_q),
        .grant_onehot (enc_onehot),
        .grant_idx    (enc_idx),
        .grant_valid  (enc_valid)
    );

    always_comb begin
        g_valid          = s_axis_in_tvalid[grant_q];
        g_data           = s_axis_in_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        g_keep           = IF_STREAM != 0 ? s_axis_in_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH] : '1;
        g_last           = IF_STREAM != 0 ? s_axis_in_tlast[grant_q] : 1'b1;
        hs               = state_q == LOCK && g_valid && out_ready;
        s_axis_in_tready = state_q == LOCK && out_ready ? grant_oh_q : '0;
        state_d          = state_q;
        grant_d          = grant_q;
        grant_oh_d       = grant_oh_q;
        last_grant_d     = last_grant_q;
        if (state_q == IDLE && enc_valid) begin
            state_d      = LOCK;
            grant_d      = enc_idx;
            grant_oh_d   = enc_onehot;
            last_grant_d = enc_idx;
        end
        if (hs && g_last)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_oh_q   <= PORT_COUNT'(1);
            last_grant_q <= IW'(PORT_COUNT - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_oh_q   <= grant_oh_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef AXIS_FRAME_ARBITER_OUTREG_EN
    logic [EW-1:0] buf_q [2];
    logic [EW-1:0] buf_d [2];
    logic          wr_q, wr_d, rd_q, rd_d, pop;
    logic [1:0]    cnt_q, cnt_d;

    assign out_ready = cnt_q != 2'd2;
    assign m_axis_out_tvalid = cnt_q != 2'd0;
    assign {m_axis_out_tdata, m_axis_out_tkeep, m_axis_out_tlast} = buf_q[rd_q];

    always_comb begin
        buf_d = buf_q;
        if (hs)
            buf_d[wr_q] = {g_data, g_keep, g_last};
        pop   = cnt_q != 2'd0 && m_axis_out_tready;
        wr_d  = wr_q ^ hs;
        rd_d  = rd_q ^ pop;
        cnt_d = cnt_q + 2'(hs) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            buf_q <= buf_d;
        end
    end
`else
    assign out_ready         = m_axis_out_tready;
    assign m_axis_out_tvalid = state_q == LOCK && g_valid;
    assign m_axis_out_tdata  = g_data;
    assign m_axis_out_tkeep  = g_keep;
    assign m_axis_out_tlast  = g_last;
`endif
endmodule

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: payload width per port.
REQ-002 SHALL have parameter IF_STREAM, default 1: 1 means multi-beat frames delimited by tlast; 0 means every beat is a complete frame.
REQ-003 SHALL have parameter KEEP_WIDTH, default IF_STREAM ? DATA_WIDTH/8 : 1: tkeep width per port.
REQ-004 SHALL have parameter PORT_COUNT, default 2: number of merged input streams, 2..16.
REQ-005 SHALL have port clk, input, 1: single clock for the whole block.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports s_axis_in_tdata/tkeep/tvalid/tlast, inputs, PORT_COUNT*DATA_WIDTH / PORT_COUNT*KEEP_WIDTH / PORT_COUNT / PORT_COUNT: packed input streams, port i in slice i.
REQ-008 SHALL have port s_axis_in_tready, output, PORT_COUNT: per-port ready.
REQ-009 SHALL have ports m_axis_out_tdata/tkeep/tvalid/tlast, outputs, DATA_WIDTH/KEEP_WIDTH/1/1, and m_axis_out_tready, input, 1: merged stream.

Function
REQ-010 SHALL run FSM IDLE -> LOCK -> IDLE; in IDLE, when any tvalid is high, it SHALL pick a grant round-robin starting at last_grant+1 modulo PORT_COUNT, register grant and last_grant, and enter LOCK the next cycle.
REQ-011 SHALL in IDLE drive every s_axis_in_tready bit at 0: one bubble cycle per frame.
REQ-012 SHALL in LOCK pass only the granted port: s_axis_in_tready[grant] = output-side ready; all other ready bits 0.
REQ-013 SHALL never interleave beats of different frames on the output.
REQ-014 SHALL return to IDLE on the cycle after a handshake of the granted port with effective tlast=1; effective tlast is s_axis_in_tlast when IF_STREAM=1 and constant 1 when IF_STREAM=0.
REQ-015 SHALL drive m_axis_out_tkeep all-ones when IF_STREAM=0, and m_axis_out_tlast from effective tlast.
REQ-016 SHALL hold LOCK indefinitely when the granted port deasserts tvalid mid-frame, with no re-arbitration and no timeout.
REQ-017 SHALL arbitrate when a single port is valid, including the port just served, with no extra delay.
REQ-018 SHALL give fairness: with all PORT_COUNT ports continuously valid, each port SHALL be granted exactly once in every PORT_COUNT consecutive frames.

Reset
REQ-019 SHALL on rst: FSM to IDLE, grant to 0, last_grant to PORT_COUNT-1 so port 0 has first priority, all s_axis_in_tready bits to 0, m_axis_out_tvalid to 0, and any output register emptied.
REQ-020 SHALL on rst mid-frame abandon the frame; the partially sent frame is not completed and downstream recovery is the upstream reset's responsibility.

Configuration
REQ-021 SHALL support macro AXIS_FRAME_ARBITER_OUTREG_EN.
- Defined: a 2-entry skid register on the output. Latency 1 cycle from input handshake to m_axis_out_tvalid. m_axis_out_* are driven from flops. Output-side ready = skid not full. Full throughput is kept under m_axis_out_tready toggling.
- Undefined: the output is a combinational mux of the granted port. Latency 0. Output-side ready = m_axis_out_tready. m_axis_out_tvalid = tvalid[grant] in LOCK, else 0.

Structure
REQ-022 SHALL place the FSM state enum (IDLE, LOCK) and the PORT_COUNT range constants in the shared package ep2_axis_pkg.
REQ-023 SHALL use one sub-module, rr_priority_encoder: request vector plus last_grant in, one-hot and index grant plus valid out, purely combinational.

Verification
REQ-024 SHALL cover these scenarios with PORT_COUNT=2, IF_STREAM=1, tready constantly 1, macro undefined:
- Port 0 sends a 3-beat frame 0xA1,0xA2,0xA3 -> output beats 0xA1..0xA3, tlast only on 0xA3, first beat appears the cycle after valid.
- Both ports are continuously valid with 2-beat frames -> grant order 0,1,0,1; no interleaving; one idle bubble between frames.
- Port 1 drops tvalid for 4 cycles mid-frame while port 0 is valid -> no switch to port 0 until port 1's tlast.
- m_axis_out_tready is held 0 for 5 cycles in LOCK -> tdata is stable and s_axis_in_tready[grant]=0 throughout; no beat is lost.
- rst is asserted on beat 2 of 4 -> next cycle all ready bits 0, tvalid 0; the next grant goes to port 0.
- With the macro defined, tready alternates 1,0 -> every beat is delivered in order and throughput equals 50% of the cycles.
